// File: rtl/path_delay_shaper.sv
// path_delay_shaper: cycle-based (in => out) = (rise, fall) path delay.
// Each sampled input edge is timestamped and queued. It retires to the
// output once its due time is reached. Narrow pulses are removed (reject
// band) or propagated with out_x set (error band). An edge pair that would
// reorder at the output is cancelled.
module path_delay_shaper #(
  parameter int RISE_DLY   = 4,
  parameter int FALL_DLY   = 6,
  parameter int REJECT_LIM = 2,
  parameter int ERROR_LIM  = 3,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_sig,
  output logic out_sig,
  output logic out_x,
  output logic cancel_pulse,
  output logic busy,
  output logic ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] RISE_C   = CNT_W'(RISE_DLY);
  localparam logic [CNT_W-1:0] FALL_C   = CNT_W'(FALL_DLY);
  localparam logic [CNT_W-1:0] REJ_C    = CNT_W'(REJECT_LIM);
  localparam logic [CNT_W-1:0] ERR_C    = CNT_W'(ERROR_LIM);
  localparam logic [CNT_W-1:0] NOW_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  // Circular pointer arithmetic; the pointers wrap at DEPTH, which need
  // not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_ONE;
  endfunction

  // Free-running timestamp and the registered input used for edge detection.
  logic [CNT_W-1:0] now;
  logic             in_q;

  // Event queue storage. The tail pointer is the next free slot, so the most
  // recently pushed entry lives at ptr_dec(tail).
  logic             q_lvl [DEPTH];
  logic             q_err [DEPTH];
  logic [CNT_W-1:0] q_due [DEPTH];
  logic [CNT_W-1:0] q_ts  [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  // Decision signals for the current cycle.
  logic             edge_seen;
  logic             nonempty;
  logic             full;
  logic [PTR_W-1:0] last;
  logic [CNT_W-1:0] cand_due;
  logic [CNT_W-1:0] w;
  logic [CNT_W-1:0] cand_lead;
  logic [CNT_W-1:0] tail_lead;
  logic             want_push;
  logic             do_push;
  logic             do_drop;
  logic             do_mark;
  logic             do_cancel;
  logic             do_retire;
  logic [PTR_W:0]   count_nxt;

  // Classify the incoming edge against the newest queued edge, and find out
  // whether the oldest entry is due this cycle.
  always_comb begin
    edge_seen = in_sig ^ in_q;
    nonempty  = (count != '0);
    full      = (count == CNT_FULL);
    last      = ptr_dec(tail);
    cand_due  = now + (in_sig ? RISE_C : FALL_C);
    w         = now - q_ts[last];
    // Distances to the output edge are compared relative to now, so they
    // stay correct across timestamp wrap.
    cand_lead = cand_due - now;
    tail_lead = q_due[last] - now;
    want_push = 1'b0;
    do_mark   = 1'b0;
    do_cancel = 1'b0;
    if (edge_seen) begin
      if (!nonempty) begin
        want_push = 1'b1;
      end else if (w < REJ_C) begin
        do_cancel = 1'b1;
      end else if (cand_lead <= tail_lead) begin
        do_cancel = 1'b1;
      end else begin
        want_push = 1'b1;
        do_mark   = (w < ERR_C);
      end
    end
    do_push   = want_push && !full;
    do_drop   = want_push && full;
    // The tail is only marked when its closing edge actually enters the queue.
    do_mark   = do_mark && !full;
    do_retire = nonempty && (q_due[head] == now);
    count_nxt = count;
    if (do_push)   count_nxt = count_nxt + CNT_ONE;
    if (do_retire) count_nxt = count_nxt - CNT_ONE;
    if (do_cancel) count_nxt = count_nxt - CNT_ONE;
  end

  // Control state: timestamp, pointers, occupancy and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now          <= '0;
      in_q         <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= 1'b0;
      out_sig      <= 1'b0;
      out_x        <= 1'b0;
      cancel_pulse <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      now          <= now + NOW_ONE;
      in_q         <= in_sig;
      count        <= count_nxt;
      busy         <= (count_nxt != '0);
      cancel_pulse <= do_cancel;
      if (do_drop) ovf <= 1'b1;
      if (do_push) tail <= ptr_inc(tail);
      if (do_cancel) tail <= last;
      if (do_retire) begin
        head    <= ptr_inc(head);
        out_sig <= q_lvl[head];
        out_x   <= q_err[head];
      end
    end
  end

  // Queue payload; the entries carry no reset because occupancy is tracked
  // by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_lvl[tail] <= in_sig;
      q_err[tail] <= 1'b0;
      q_due[tail] <= cand_due;
      q_ts[tail]  <= now;
    end
    if (do_mark) q_err[last] <= 1'b1;
  end

endmodule
